// File: rtl/rtc_pkg.sv
// RTC calendar shared definitions: date field layout, controller states
// and BCD calendar helpers.
package rtc_pkg;

    localparam int DAY_LSB  = 0;
    localparam int DAY_W    = 6;
    localparam int MON_LSB  = 8;
    localparam int MON_W    = 5;
    localparam int YEAR_LSB = 16;
    localparam int YEAR_W   = 14;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        APPLY,
        RESP
    } state_e;

    // A BCD two-digit value is a multiple of 4 iff the ones digit fits the tens parity
    function automatic logic bcd_div4(input logic [3:0] tens,
                                      input logic [3:0] ones);
        if (tens[0])
            return (ones == 4'd2) || (ones == 4'd6);
        return (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
    endfunction

    function automatic logic [5:0] days_in_month(input logic [4:0] month,
                                                 input logic       leap);
        case (month)
            5'h02:                      days_in_month = leap ? 6'h29 : 6'h28;
            5'h04, 5'h06, 5'h09, 5'h11: days_in_month = 6'h30;
            default:                    days_in_month = 6'h31;
        endcase
    endfunction

endpackage

// File: rtl/rtc_date_check.sv
// Combinational BCD calendar date validator (reserved bits, digits,
// month range, day range with leap-year February).
module rtc_date_check
    import rtc_pkg::*;
(
    input  logic [31:0] date_i,
    output logic        valid_o
);

    logic [DAY_W-1:0]  day;
    logic [MON_W-1:0]  mon;
    logic [YEAR_W-1:0] yr;
    logic              rsv_ok;
    logic              nib_ok;
    logic              leap;
    logic              mon_ok;
    logic              day_ok;
    logic [5:0]        dim;

    assign day = date_i[DAY_LSB +: DAY_W];
    assign mon = date_i[MON_LSB +: MON_W];
    assign yr  = date_i[YEAR_LSB +: YEAR_W];

    assign rsv_ok = (date_i[31:30] == 2'b00) && (date_i[15:13] == 3'b000)
                 && (date_i[7:6] == 2'b00);

    assign nib_ok = (day[3:0] <= 4'd9) && (mon[3:0] <= 4'd9)
                 && (yr[3:0] <= 4'd9) && (yr[7:4] <= 4'd9)
                 && (yr[11:8] <= 4'd9);

    // Centuries are leap only when the hundreds field is itself a multiple of 4
    assign leap = (yr[7:0] == 8'h00) ? bcd_div4({2'b00, yr[13:12]}, yr[11:8])
                                     : bcd_div4(yr[7:4], yr[3:0]);

    assign dim    = days_in_month(mon, leap);
    assign mon_ok = (mon != 5'h00) && (mon <= 5'h12);
    assign day_ok = (day != 6'h00) && (day <= dim);

    assign valid_o = rsv_ok && nib_ok && mon_ok && day_ok;

endmodule

// File: rtl/rtc_date_ctrl.sv
// Calendar write sequencer: round-robin date-set arbitration, validation,
// rollover-safe load strobe and date alarm.
module rtc_date_ctrl
    import rtc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req0_valid_i,
    input  logic        req1_valid_i,
    input  logic [31:0] req0_date_i,
    input  logic [31:0] req1_date_i,
    output logic        req0_ready_o,
    output logic        req1_ready_o,
    output logic        req0_done_o,
    output logic        req1_done_o,
    output logic        req0_err_o,
    output logic        req1_err_o,
    input  logic        new_day_i,
    output logic        new_day_o,
    input  logic [31:0] date_i,
    output logic        date_update_o,
    output logic [31:0] date_o,
    input  logic        alarm_en_i,
    input  logic [31:0] alarm_date_i,
    output logic        alarm_irq_o
);

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        gnt_q, gnt_d;
    logic        err_q, err_d;
    logic [31:0] pend_q, pend_d;
    logic        match_q;
    logic        irq_q;
    logic        match;
    logic        pend_ok;
    logic        idle;
    logic        grant0;
    logic        grant1;
    logic        done;

    rtc_date_check u_check (
        .date_i  (pend_q),
        .valid_o (pend_ok)
    );

    // ptr_q == 1 favours requester 1 when both are valid
    assign idle   = (state_q == IDLE);
    assign grant0 = idle & req0_valid_i & (~req1_valid_i | ~ptr_q);
    assign grant1 = idle & req1_valid_i & (~req0_valid_i | ptr_q);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gnt_d         = gnt_q;
        err_d         = err_q;
        pend_d        = pend_q;
        date_update_o = 1'b0;
        done          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    pend_d  = grant1 ? req1_date_i : req0_date_i;
                    gnt_d   = grant1;
                    ptr_d   = ~grant1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                err_d   = ~pend_ok;
                state_d = pend_ok ? APPLY : RESP;
            end
            APPLY: begin
                date_update_o = ~new_day_i;
                if (!new_day_i)
                    state_d = RESP;
            end
            RESP: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= '0;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            match_q <= match;
            irq_q   <= match & ~match_q;
        end
    end

    assign match = alarm_en_i & (date_i == alarm_date_i);

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;
    assign req0_done_o  = done & ~gnt_q;
    assign req1_done_o  = done & gnt_q;
    assign req0_err_o   = done & ~gnt_q & err_q;
    assign req1_err_o   = done & gnt_q & err_q;
    assign new_day_o    = new_day_i;
    assign date_o       = pend_q;
    assign alarm_irq_o  = irq_q;

endmodule
